// File: rtl/cbus_pkg.sv
// Shared C-bus/B-bus destination codes and write-back FSM state.
// Imported by cbus_writeback, cbus_mem_wr and the B-bus mux.
package cbus_pkg;

    localparam logic [3:0] CF_NONE = 4'd0;
    localparam logic [3:0] CF_PC   = 4'd1;
    localparam logic [3:0] CF_R    = 4'd2;
    localparam logic [3:0] CF_R1   = 4'd3;
    localparam logic [3:0] CF_R2   = 4'd4;
    localparam logic [3:0] CF_R3   = 4'd5;
    localparam logic [3:0] CF_R4   = 4'd6;
    localparam logic [3:0] CF_TR   = 4'd7;
    localparam logic [3:0] CF_TR2  = 4'd8;
    localparam logic [3:0] CF_TR4  = 4'd9;
    localparam logic [3:0] CF_AC   = 4'd10;
    localparam logic [3:0] CF_MEM  = 4'd11;
    localparam logic [3:0] CF_R5   = 4'd12;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } wr_state_t;

endpackage

// File: rtl/cbus_mem_wr.sv
// Byte write to data memory: IDLE/WAIT req/ack FSM.
// In: req, wdata, addr, mem_ack. Out: mem_addr, mem_wdata, mem_we, busy, wr_err.
module cbus_mem_wr
    import cbus_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [7:0]        wdata,
    input  logic [MEM_AW-1:0] addr,
    input  logic              mem_ack,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              wr_err
);

    wr_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        mem_wdata <= wdata;
                        mem_addr  <= addr;
                        mem_we    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // a second request while busy is dropped
                    if (req)
                        wr_err <= 1'b1;
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cbus_writeback.sv
// C-bus write-back: register file, inc strobes, memory byte write.
// In: cflag, C_bus, *_inc, mem_ack. Out: registers, mem_*, busy, wr_err,
// and z when CBUS_ZFLAG_EN is defined.
module cbus_writeback
    import cbus_pkg::*;
#(
    parameter int          MEM_AW   = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        cflag,
    input  logic [15:0]       C_bus,
    input  logic              pc_inc,
    input  logic              r1_inc,
    input  logic              r2_inc,
    input  logic              ac_inc,
    input  logic              mem_ack,
    output logic [15:0]       PC,
    output logic [15:0]       R,
    output logic [15:0]       R1,
    output logic [15:0]       R2,
    output logic [15:0]       R3,
    output logic [15:0]       R4,
    output logic [15:0]       R5,
    output logic [15:0]       TR,
    output logic [15:0]       TR2,
    output logic [15:0]       TR4,
    output logic [15:0]       AC,
`ifdef CBUS_ZFLAG_EN
    output logic              z,
`endif
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              wr_err
);

    // increments first, write last: same-register write overrides inc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC  <= RESET_PC;
            R   <= '0;
            R1  <= '0;
            R2  <= '0;
            R3  <= '0;
            R4  <= '0;
            R5  <= '0;
            TR  <= '0;
            TR2 <= '0;
            TR4 <= '0;
            AC  <= '0;
        end else begin
            if (pc_inc) PC <= PC + 16'd1;
            if (r1_inc) R1 <= R1 + 16'd1;
            if (r2_inc) R2 <= R2 + 16'd1;
            if (ac_inc) AC <= AC + 16'd1;
            case (cflag)
                CF_PC:   PC  <= C_bus;
                CF_R:    R   <= C_bus;
                CF_R1:   R1  <= C_bus;
                CF_R2:   R2  <= C_bus;
                CF_R3:   R3  <= C_bus;
                CF_R4:   R4  <= C_bus;
                CF_TR:   TR  <= C_bus;
                CF_TR2:  TR2 <= C_bus;
                CF_TR4:  TR4 <= C_bus;
                CF_AC:   AC  <= C_bus;
                CF_R5:   R5  <= C_bus;
                default: ;
            endcase
        end
    end

`ifdef CBUS_ZFLAG_EN
    logic        ac_wr;
    logic [15:0] ac_next;

    always_comb begin
        ac_wr   = (cflag == CF_AC);
        ac_next = ac_wr ? C_bus : AC + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            z <= 1'b0;
        else if (ac_wr || ac_inc)
            z <= (ac_next == 16'h0000);
    end
`endif

    cbus_mem_wr #(
        .MEM_AW(MEM_AW)
    ) u_mem_wr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (cflag == CF_MEM),
        .wdata     (C_bus[7:0]),
        .addr      (R[MEM_AW-1:0]),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .wr_err    (wr_err)
    );

endmodule

// File: tb/tb_cbus_writeback.sv
// Directed self-checking bench for cbus_writeback.
// Build with +define+CBUS_ZFLAG_EN to also cover the z flag.
module tb_cbus_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cflag;
    logic [15:0] C_bus;
    logic        pc_inc, r1_inc, r2_inc, ac_inc;
    logic        mem_ack;
    logic [15:0] PC, R, R1, R2, R3, R4, R5;
    logic [15:0] TR, TR2, TR4, AC;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, busy, wr_err;
`ifdef CBUS_ZFLAG_EN
    logic        z;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cbus_writeback #(
        .MEM_AW   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cflag     (cflag),
        .C_bus     (C_bus),
        .pc_inc    (pc_inc),
        .r1_inc    (r1_inc),
        .r2_inc    (r2_inc),
        .ac_inc    (ac_inc),
        .mem_ack   (mem_ack),
        .PC        (PC),
        .R         (R),
        .R1        (R1),
        .R2        (R2),
        .R3        (R3),
        .R4        (R4),
        .R5        (R5),
        .TR        (TR),
        .TR2       (TR2),
        .TR4       (TR4),
        .AC        (AC),
`ifdef CBUS_ZFLAG_EN
        .z         (z),
`endif
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .wr_err    (wr_err)
    );

    // advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cflag   = 4'd0;
        C_bus   = 16'h0000;
        pc_inc  = 1'b0;
        r1_inc  = 1'b0;
        r2_inc  = 1'b0;
        ac_inc  = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [159:0] regs;
        rst_n = 1'b0;
        idle_in();
        #3;
        regs = {R, R1, R2, R3, R4, R5, TR, TR2, TR4, AC};
        checks++;
        if (PC !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pc got %h want 0000", PC);
        end
        checks++;
        if (regs !== 160'h0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", regs);
        end
        checks++;
        if ({mem_we, busy, wr_err, mem_wdata, mem_addr} !== 27'h0) begin
            errors++;
            $display("FAIL reset_mem we=%b busy=%b err=%b d=%h a=%h",
                     mem_we, busy, wr_err, mem_wdata, mem_addr);
        end
        #4 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reg_write();
        logic [3:0]  codes [9] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7,
                                   4'd8, 4'd9, 4'd10, 4'd12};
        logic [15:0] got;
        logic [15:0] want;
        cflag = 4'd3;
        C_bus = 16'h1234;
        tick();
        idle_in();
        checks++;
        if (R1 !== 16'h1234) begin
            errors++;
            $display("FAIL wr_r1 got %h want 1234", R1);
        end
        checks++;
        if ({PC, R, R2, R3, R4, R5, TR, TR2, TR4, AC} !== 160'h0) begin
            errors++;
            $display("FAIL wr_r1_others_not_zero");
        end
        foreach (codes[i]) begin
            want  = {4'hA, codes[i], 4'h5, codes[i]};
            cflag = codes[i];
            C_bus = want;
            tick();
            idle_in();
            case (codes[i])
                4'd2:    got = R;
                4'd4:    got = R2;
                4'd5:    got = R3;
                4'd6:    got = R4;
                4'd7:    got = TR;
                4'd8:    got = TR2;
                4'd9:    got = TR4;
                4'd10:   got = AC;
                default: got = R5;
            endcase
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL wr_code%0d got %h want %h",
                         codes[i], got, want);
            end
        end
        // codes 0 and 13-15 write nothing
        for (int c = 13; c < 16; c++) begin
            cflag = 4'(c);
            C_bus = 16'hDEAD;
            tick();
        end
        idle_in();
        checks++;
        if (PC !== 16'h0000 || R !== 16'hA252 || R1 !== 16'h1234 ||
            AC !== 16'hAA5A || R5 !== 16'hAC5C) begin
            errors++;
            $display("FAIL nowrite_codes pc=%h r=%h r1=%h ac=%h r5=%h",
                     PC, R, R1, AC, R5);
        end
    endtask

    task automatic test_inc();
        cflag = 4'd1;
        C_bus = 16'hFFFF;
        tick();
        idle_in();
        pc_inc = 1'b1;
        tick();
        idle_in();
        checks++;
        if (PC !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap got %h want 0000", PC);
        end
        cflag  = 4'd1;
        C_bus  = 16'h00A0;
        pc_inc = 1'b1;
        tick();
        idle_in();
        checks++;
        if (PC !== 16'h00A0) begin
            errors++;
            $display("FAIL pc_write_wins got %h want 00a0", PC);
        end
        cflag = 4'd4;
        C_bus = 16'hFFFF;
        tick();
        cflag = 4'd10;
        C_bus = 16'h0010;
        tick();
        idle_in();
        pc_inc = 1'b1;
        r1_inc = 1'b1;
        r2_inc = 1'b1;
        ac_inc = 1'b1;
        tick();
        idle_in();
        checks++;
        if ({PC, R1, R2, AC} !== {16'h00A1, 16'h1235, 16'h0000, 16'h0011}) begin
            errors++;
            $display("FAIL multi_inc got %h %h %h %h want 00a1 1235 0000 0011",
                     PC, R1, R2, AC);
        end
    endtask

    task automatic test_mem_write();
        cflag = 4'd2;
        C_bus = 16'h0040;
        tick();
        cflag = 4'd11;
        C_bus = 16'hBE5A;
        tick();
        idle_in();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({mem_we, busy, mem_wdata, mem_addr} !== {2'b11, 8'h5A, 16'h0040}) begin
                errors++;
                $display("FAIL mem_hold%0d we=%b busy=%b d=%h a=%h",
                         k, mem_we, busy, mem_wdata, mem_addr);
            end
            if (k == 0) begin
                cflag = 4'd2;
                C_bus = 16'h7777;
            end else if (k == 2) begin
                mem_ack = 1'b1;
            end
            if (k < 2)
                tick();
            if (k == 0)
                idle_in();
        end
        tick();
        idle_in();
        checks++;
        if ({mem_we, busy, wr_err} !== 3'b000) begin
            errors++;
            $display("FAIL mem_ack_clear we=%b busy=%b err=%b want 000",
                     mem_we, busy, wr_err);
        end
        checks++;
        if (R !== 16'h7777 || mem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL r_write_in_wait r=%h a=%h want 7777 0040",
                     R, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        tick();
        idle_in();
        checks++;
        if ({mem_we, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ack_in_idle we=%b busy=%b want 00", mem_we, busy);
        end
    endtask

    task automatic test_wait_conflict();
        cflag = 4'd2;
        C_bus = 16'h0040;
        tick();
        cflag = 4'd11;
        C_bus = 16'hBE5A;
        tick();
        cflag = 4'd11;
        C_bus = 16'h1277;
        tick();
        checks++;
        if ({wr_err, mem_we, mem_wdata} !== {2'b11, 8'h5A}) begin
            errors++;
            $display("FAIL wait_conflict err=%b we=%b d=%h want 1 1 5a",
                     wr_err, mem_we, mem_wdata);
        end
        cflag = 4'd10;
        C_bus = 16'h0007;
        tick();
        idle_in();
        checks++;
        if (AC !== 16'h0007 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ac_in_wait ac=%h busy=%b want 0007 1", AC, busy);
        end
        mem_ack = 1'b1;
        tick();
        idle_in();
        tick();
        checks++;
        if ({wr_err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL err_sticky err=%b busy=%b want 1 0", wr_err, busy);
        end
    endtask

    task automatic test_async_reset();
        cflag = 4'd11;
        C_bus = 16'h0033;
        tick();
        idle_in();
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_we got %b want 1", mem_we);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, busy, wr_err} !== 3'b000) begin
            errors++;
            $display("FAIL async_rst_mem we=%b busy=%b err=%b want 000",
                     mem_we, busy, wr_err);
        end
        checks++;
        if ({PC, R, R1, R2, R3, R4, R5, TR, TR2, TR4, AC} !== 176'h0) begin
            errors++;
            $display("FAIL async_rst_regs pc=%h r=%h ac=%h", PC, R, AC);
        end
        #2 rst_n = 1'b1;
        mem_ack = 1'b0;
        tick();
        tick();
        checks++;
        if ({mem_we, busy} !== 2'b00) begin
            errors++;
            $display("FAIL pending_lost we=%b busy=%b want 00", mem_we, busy);
        end
    endtask

`ifdef CBUS_ZFLAG_EN
    task automatic test_zflag();
        cflag = 4'd10;
        C_bus = 16'hFFFF;
        tick();
        idle_in();
        checks++;
        if (z !== 1'b0) begin
            errors++;
            $display("FAIL z_ffff got %b want 0", z);
        end
        ac_inc = 1'b1;
        tick();
        idle_in();
        checks++;
        if (AC !== 16'h0000 || z !== 1'b1) begin
            errors++;
            $display("FAIL z_wrap ac=%h z=%b want 0000 1", AC, z);
        end
        cflag = 4'd3;
        C_bus = 16'h0005;
        tick();
        checks++;
        if (z !== 1'b1) begin
            errors++;
            $display("FAIL z_hold got %b want 1", z);
        end
        cflag = 4'd10;
        C_bus = 16'h0001;
        tick();
        idle_in();
        checks++;
        if (z !== 1'b0) begin
            errors++;
            $display("FAIL z_write1 got %b want 0", z);
        end
        cflag  = 4'd10;
        C_bus  = 16'h0000;
        ac_inc = 1'b1;
        tick();
        idle_in();
        checks++;
        if (AC !== 16'h0000 || z !== 1'b1) begin
            errors++;
            $display("FAIL z_write_wins ac=%h z=%b want 0000 1", AC, z);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reg_write();
        test_inc();
        test_mem_write();
        test_wait_conflict();
        test_async_reset();
`ifdef CBUS_ZFLAG_EN
        test_zflag();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbus_writeback.md
Name: cbus_writeback

Overview:
Write-back end of the datapath bus pair: the B-bus mux drives a source onto B_bus, and this block takes the ALU result on C_bus and writes it into the register selected by a 4-bit cflag.
- Holds the architectural registers PC, R, R1-R5, TR, TR2, TR4 and AC, and feeds them to the B-bus mux.
- Provides increment strobes for PC/R1/R2/AC.
- Handles byte writes to data memory with a req/ack FSM.

Parameters:
- MEM_AW, 16, width of the registered memory write address (taken from AR-equivalent register R).
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cflag  in  4  destination select, same code map as bflag
- C_bus  in  16  write-back data
- pc_inc  in  1  PC <= PC+1
- r1_inc  in  1  R1 <= R1+1
- r2_inc  in  1  R2 <= R2+1
- ac_inc  in  1  AC <= AC+1
- mem_ack  in  1  memory accepted byte write
- PC,R,R1,R2,R3,R4,R5,TR,TR2,TR4,AC  out  16 each  register contents (to B-bus mux)
- mem_addr  out  MEM_AW  write address, captured from R
- mem_wdata  out  8  write byte
- mem_we  out  1  write request
- busy  out  1  memory write outstanding
- wr_err  out  1  sticky: Mem write requested while busy

Behaviour:
- Reset: all outputs clear immediately on rst_n low, with these values:
  - PC = RESET_PC.
  - All other registers = 0.
  - mem_we = 0, busy = 0, wr_err = 0, mem_wdata = 0, mem_addr = 0.
- cflag codes:
  - 1 PC, 2 R, 3 R1, 4 R2, 5 R3, 6 R4, 7 TR, 8 TR2, 9 TR4, 10 AC, 11 Mem, 12 R5.
  - 0 and 13-15: no write.
- Register write: selected register <= C_bus at the rising edge. One-cycle latency; the new value is visible on the output port in the next cycle.
- Increments:
  - Applied in the same edge as writes.
  - Wrap 16'hFFFF -> 16'h0000, no flag.
  - Several inc strobes in one cycle are all honoured.
- Write and increment on the same register in the same cycle: write wins, increment discarded.
- Memory write FSM, states IDLE and WAIT:
  - IDLE, cflag=11: capture mem_wdata <= C_bus[7:0] and mem_addr <= R[MEM_AW-1:0]. Next cycle mem_we=1, busy=1 -> WAIT.
  - WAIT: hold mem_we, mem_wdata and mem_addr stable until mem_ack=1 is sampled. On that edge mem_we=0, busy=0 -> IDLE. Earliest next request is the following cycle.
  - WAIT, cflag=11: request dropped, wr_err <= 1 (sticky until reset). Register writes for other codes proceed normally while busy.
  - mem_ack in IDLE: ignored.
  - Writes to R while in WAIT do not disturb the captured mem_addr.
- rst_n asserted mid-WAIT: FSM returns to IDLE, mem_we drops asynchronously, and the pending write is lost.
- Unused C_bus[15:8] on Mem writes is ignored.

Optional Feature:
- Macro CBUS_ZFLAG_EN.
- Defined: adds output z (1 bit, reset 0), registered along with AC. Z equals (next AC == 0) whenever AC is updated by a write or ac_inc; otherwise z holds its value. An inc wrap to 0 sets z=1.
- Undefined: no z port, no extra logic.

Decomposition:
- Package cbus_pkg:
  - cflag/bflag code constants (CF_NONE=0, CF_PC=1 ... CF_MEM=11, CF_R5=12), shared with the B-bus mux.
  - FSM state typedef {ST_IDLE, ST_WAIT}.
- Sub-module cbus_mem_wr: contains the IDLE/WAIT FSM, data/address capture, mem_we/busy/wr_err. The top holds the register file and the increment logic.

Test Plan:
- Reset release, then cflag=3, C_bus=16'h1234 for one cycle -> R1=16'h1234 the next cycle; all other registers 0; PC=RESET_PC.
- PC=16'hFFFF, pc_inc=1 -> PC=16'h0000. Same cycle cflag=1, C_bus=16'h00A0, pc_inc=1 -> PC=16'h00A0.
- R=16'h0040, cflag=11, C_bus=16'hBE5A, mem_ack low for 3 cycles then high:
  - mem_we=1, busy=1, mem_wdata=8'h5A, mem_addr=16'h0040, all held 3 cycles.
  - Clear on the ack edge.
- During WAIT, cflag=11 again -> wr_err=1 and mem_wdata still 8'h5A. A concurrent cflag=10, C_bus=16'h0007 in WAIT -> AC=16'h0007.
- rst_n pulsed low mid-WAIT (between clock edges) -> mem_we=0 and busy=0 immediately; all registers reset.
- With CBUS_ZFLAG_EN:
  - AC=16'hFFFF, ac_inc -> AC=0, z=1.
  - Then cflag=10, C_bus=16'h0001 -> z=0.
  - cflag=3 writes -> z unchanged.
